// File: rtl/mem_store_rmw_pkg.sv
// Parametros: shared constants and types for the store-side memory controller.
//   FUNCT3_SB/SH/SW : store-type encodings carried on funct3
//   store_state_t   : FSM state encoding for mem_store_rmw
package Parametros;

    localparam logic [2:0] FUNCT3_SB = 3'b000;
    localparam logic [2:0] FUNCT3_SH = 3'b001;
    localparam logic [2:0] FUNCT3_SW = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_WRITE,
        ST_DONE
    } store_state_t;

endpackage

// File: rtl/mem_store_rmw_merge.sv
// MemStoreMerge: combinational lane merge for sub-word stores.
//   iFunct3     : store type (SB/SH/SW, anything else is unsupported)
//   iAddrLo     : byte offset within the word, addr[1:0]
//   iData       : store data, LSB-justified
//   iRData      : current memory word (ignored for SW)
//   oMerged     : word to write back
//   oByteEn     : lanes replaced by store data (0 for rejected stores)
//   oMisaligned : SH at odd address or SW at non-word address
module MemStoreMerge
    import Parametros::*;
(
    input  logic [2:0]  iFunct3,
    input  logic [1:0]  iAddrLo,
    input  logic [31:0] iData,
    input  logic [31:0] iRData,
    output logic [31:0] oMerged,
    output logic [3:0]  oByteEn,
    output logic        oMisaligned
);

    always_comb begin
        oMerged     = iRData;
        oByteEn     = '0;
        oMisaligned = 1'b0;
        case (iFunct3)
            FUNCT3_SB: begin
                oByteEn                          = 4'b0001 << iAddrLo;
                oMerged[{iAddrLo, 3'b000} +: 8] = iData[7:0];
            end
            FUNCT3_SH: begin
                if (iAddrLo[0]) begin
                    oMisaligned = 1'b1;
                end else if (iAddrLo[1]) begin
                    oByteEn        = 4'b1100;
                    oMerged[31:16] = iData[15:0];
                end else begin
                    oByteEn       = 4'b0011;
                    oMerged[15:0] = iData[15:0];
                end
            end
            FUNCT3_SW: begin
                if (iAddrLo != 2'b00) begin
                    oMisaligned = 1'b1;
                end else begin
                    oByteEn = 4'b1111;
                    oMerged = iData;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_store_rmw.sv
// mem_store_rmw: store controller between the core memory stage and a
// word-only data memory. SW writes directly; SB/SH do read-modify-write;
// misaligned or unsupported stores are rejected without memory access.
//   iCLK/iRSTn            : clock, async active-low reset
//   iReq/iFunct3/iAddress/iWriteData : store request, taken while oReady=1
//   oReady/oDone          : idle indicator, one-cycle completion pulse
//   oMisaligned/oFault    : completion status, valid with oDone
//   oMemAddr/oMemRead/iMemRData/iMemValid : word read port
//   oMemWrite/oMemWData/oMemByteEn        : word write port
module mem_store_rmw
    import Parametros::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic        iCLK,
    input  logic        iRSTn,
    input  logic        iReq,
    input  logic [2:0]  iFunct3,
    input  logic [31:0] iAddress,
    input  logic [31:0] iWriteData,
    output logic        oReady,
    output logic        oDone,
    output logic        oMisaligned,
    output logic        oFault,
    output logic [31:0] oMemAddr,
    output logic        oMemRead,
    input  logic [31:0] iMemRData,
    input  logic        iMemValid,
    output logic        oMemWrite,
    output logic [31:0] oMemWData,
    output logic [3:0]  oMemByteEn
);

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    store_state_t state_q, state_d;
    logic [31:0]  addr_q, addr_d;
    logic [2:0]   funct3_q, funct3_d;
    logic [31:0]  data_q, data_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [31:0]  wdata_q, wdata_d;
    logic [3:0]   be_q, be_d;
    logic         mis_q, mis_d;
    logic         fault_q, fault_d;

    logic [2:0]   mrg_funct3;
    logic [1:0]   mrg_addr_lo;
    logic [31:0]  mrg_data;
    logic [31:0]  mrg_word;
    logic [3:0]   mrg_be;
    logic         mrg_mis;
    logic         unsupported;

    // One merge instance serves both phases: in IDLE it classifies the
    // incoming request, afterwards it merges the latched request with
    // the returned memory word.
    always_comb begin
        if (state_q == ST_IDLE) begin
            mrg_funct3  = iFunct3;
            mrg_addr_lo = iAddress[1:0];
            mrg_data    = iWriteData;
        end else begin
            mrg_funct3  = funct3_q;
            mrg_addr_lo = addr_q[1:0];
            mrg_data    = data_q;
        end
    end

    MemStoreMerge u_merge (
        .iFunct3     (mrg_funct3),
        .iAddrLo     (mrg_addr_lo),
        .iData       (mrg_data),
        .iRData      (iMemRData),
        .oMerged     (mrg_word),
        .oByteEn     (mrg_be),
        .oMisaligned (mrg_mis)
    );

    assign unsupported = (iFunct3 != FUNCT3_SB) && (iFunct3 != FUNCT3_SH) &&
                         (iFunct3 != FUNCT3_SW);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        funct3_d = funct3_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        mis_d    = mis_q;
        fault_d  = fault_q;
        case (state_q)
            ST_IDLE: begin
                if (iReq) begin
                    addr_d   = iAddress;
                    funct3_d = iFunct3;
                    data_d   = iWriteData;
                    mis_d    = mrg_mis;
                    fault_d  = unsupported;
                    be_d     = mrg_be;
                    if (mrg_mis || unsupported) begin
                        state_d = ST_DONE;
                    end else if (iFunct3 == FUNCT3_SW) begin
                        wdata_d = mrg_word;
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Valid data takes priority over an expiring timeout.
                if (iMemValid) begin
                    wdata_d = mrg_word;
                    state_d = ST_WRITE;
                end else if (cnt_q == LAST_WAIT) begin
                    fault_d = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_WRITE: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            funct3_q <= '0;
            data_q   <= '0;
            cnt_q    <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            mis_q    <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            mis_q    <= mis_d;
            fault_q  <= fault_d;
        end
    end

    // Strobes decode straight from state so an async reset kills them at once.
    assign oReady      = (state_q == ST_IDLE);
    assign oMemRead    = (state_q == ST_READ);
    assign oMemWrite   = (state_q == ST_WRITE);
    assign oDone       = (state_q == ST_DONE);
    assign oMisaligned = mis_q;
    assign oFault      = fault_q;
    assign oMemAddr    = {addr_q[31:2], 2'b00};
    assign oMemWData   = wdata_q;
    assign oMemByteEn  = be_q;

endmodule

// File: doc/mem_store_rmw.md
# mem_store_rmw

Store-side controller for the data memory: the write-direction counterpart of the load aligner. It accepts one store request (SB, SH or SW, selected by funct3) from the core. SW is written directly. SB/SH are turned into a read-modify-write sequence against a word-only memory port, and misaligned or unsupported stores are rejected without touching memory. It sits between the core's memory stage and the data-memory word port.

## Interface
Parameters:
- TIMEOUT, 15: maximum WAIT cycles for read data before the store is aborted with a fault (1..255).

Ports:
- iCLK  in  1  system clock, rising edge.
- iRSTn  in  1  asynchronous, active-low reset.
- iReq  in  1  store request, sampled only while oReady=1.
- iFunct3  in  3  store type: FUNCT3_SB, FUNCT3_SH, FUNCT3_SW.
- iAddress  in  32  byte address of the store.
- iWriteData  in  32  store data, LSB-justified.
- oReady  out  1  idle, able to accept iReq.
- oDone  out  1  one-cycle pulse when the store has completed or been rejected.
- oMisaligned  out  1  valid with oDone: SH with addr[0]=1, or SW with addr[1:0]!=0.
- oFault  out  1  valid with oDone: unsupported funct3 or read timeout.
- oMemAddr  out  32  word address {addr[31:2],2'b00}.
- oMemRead  out  1  one-cycle read strobe.
- iMemRData  in  32  read data word.
- iMemValid  in  1  iMemRData valid; sampled only in WAIT.
- oMemWrite  out  1  one-cycle write strobe.
- oMemWData  out  32  full word to write.
- oMemByteEn  out  4  lanes actually modified; informational for byte-enable memories.

## Operation
- The FSM has five states: IDLE, READ, WAIT, WRITE, DONE.
- **IDLE**
  - oReady=1.
  - On iReq, latch iAddress, iFunct3 and iWriteData.
  - Misaligned or unsupported funct3 -> DONE with the matching flag set.
  - SW -> WRITE.
  - SB/SH -> READ.
- **READ**
  - oMemRead=1 for one cycle.
  - Clear the wait counter, then -> WAIT.
- **WAIT**
  - iMemValid=1 -> register the merged word, then -> WRITE.
  - Otherwise increment the counter.
  - Counter reaches TIMEOUT -> DONE with oFault=1; no write is issued.
  - If iMemValid and the timeout occur in the same cycle, valid wins.
- **Merge rules**
  - SB: the lane is addr[1:0]. Byte = data[7:0]. The other three bytes are taken from iMemRData.
  - SH: the lane is addr[1]. Half = data[15:0]. The other half is taken from iMemRData.
  - SW: the word is data unchanged.
- **WRITE**
  - oMemWrite=1 for one cycle, with oMemWData = merged word, then -> DONE.
- **DONE**
  - oDone=1 for one cycle, flags held, then -> IDLE.
- **oMemByteEn**
  - SB: one-hot at addr[1:0].
  - SH: 4'b0011 or 4'b1100.
  - SW: 4'b1111.
  - Rejected stores: 0.
- oMemAddr holds the latched word address from READ through WRITE.
- iReq outside IDLE is ignored; there is no queueing.

## Timing
- Reset values: state IDLE, oReady=1. oDone, oMisaligned, oFault, oMemRead, oMemWrite and oMemByteEn are 0. oMemAddr and oMemWData are 0.
- Latency is counted from the cycle iReq is sampled (cycle 0):
  - SW: WRITE in cycle 1, oDone in cycle 2.
  - Rejected store: oDone in cycle 1.
  - SB/SH with a 1-cycle memory: READ cycle 1, WAIT with valid cycle 2, WRITE cycle 3, oDone cycle 4. Each extra wait cycle adds one.
  - Timeout: oDone in cycle 2+TIMEOUT.
- oReady returns in the cycle after oDone. Back-to-back requests are therefore accepted at the earliest one cycle after oDone.
- Reset asserted mid-operation returns to IDLE immediately. No strobe may appear after iRSTn falls, and a pending write is dropped.

## Structure
- The shared package Parametros holds:
  - the FUNCT3_SB, FUNCT3_SH and FUNCT3_SW constants;
  - the state enum type for this FSM.
- One combinational sub-module, MemStoreMerge, takes (funct3, addr[1:0], data, rdata) and produces (merged word, byte enables, misaligned).
- The top level holds the FSM, the latches and the timeout counter.

## Test plan
- SW addr 0x100, data 0xDEADBEEF -> no oMemRead; oMemWrite in cycle 1 with oMemWData=0xDEADBEEF, oMemByteEn=4'b1111; oDone in cycle 2.
- SB addr 0x103, data 0x000000AB, memory returns 0x11223344 one cycle after the read -> oMemWData=0xAB223344, byte enable 4'b1000, oDone in cycle 4.
- SH addr 0x102, data 0x0000CAFE, memory returns 0x11223344 after 3 wait cycles -> oMemWData=0xCAFE3344, oDone in cycle 6.
- SH addr 0x101 and SW addr 0x102 -> oDone in cycle 1 with oMisaligned=1 and no memory strobes; funct3=3'b011 -> oFault=1, no strobes.
- SB with iMemValid held low, TIMEOUT=15 -> oFault=1 with oDone in cycle 17 and no oMemWrite. A second run asserting valid exactly at the timeout cycle -> write proceeds with oFault=0.
- Deassert iRSTn during WAIT of an SB -> oReady=1 and all strobes 0 immediately; no write after reset release; a new SW afterwards completes normally.
